// File: rtl/uart8_transmitter_pkg.sv
// Shared definitions for the 8-bit UART: frame states, default rates and
// the bit-period calculation. The receiver imports the same package.
package uart8_transmitter_pkg;

    localparam int DEFAULT_CLOCK_RATE = 12000000;
    localparam int DEFAULT_BAUD_RATE  = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart8_transmitter_baud_tick_gen.sv
// Bit-period timer: tick pulses for one cycle every CLKS_PER_BIT cycles,
// counted from the last cycle in which clear was high.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Counter 0..CLKS_PER_BIT-1; tick is registered one count early so it
    // is high exactly while the counter sits at its last value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_r <= (cnt_r == PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart8_transmitter.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, STOP_BITS stop
// bits. A start request seen at the end of the last stop bit launches the
// next frame on the same edge, so frames can run back to back.
module uart8_transmitter
    import uart8_transmitter_pkg::*;
#(
    parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [7:0] in,
    output logic       out,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam logic STOP_LAST  = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart8_transmitter: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart8_transmitter: STOP_BITS must be 1 or 2");
    end

    uart_state_e state_r, state_s;
    logic [7:0]  shift_r, shift_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic        stop_cnt_r, stop_cnt_s;
    logic        out_r, out_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        clear_s;
    logic        tick_s;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state, datapath and next-output logic; the timer is held clear
    // while idle and on every frame launch so the first bit is full length.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        out_s      = out_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        clear_s    = 1'b0;
        if (!en) begin
            state_s    = IDLE;
            bit_cnt_s  = 3'd0;
            stop_cnt_s = 1'b0;
            out_s      = 1'b1;
            busy_s     = 1'b0;
            clear_s    = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    clear_s    = 1'b1;
                    bit_cnt_s  = 3'd0;
                    stop_cnt_s = 1'b0;
                    if (start) begin
                        shift_s = in;
                        state_s = START;
                        out_s   = 1'b0;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                        out_s   = 1'b1;
                        busy_s  = 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_s = DATA;
                        out_s   = shift_r[0];
                    end else begin
                        out_s = 1'b0;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_s = {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_s    = STOP;
                            bit_cnt_s  = 3'd0;
                            stop_cnt_s = 1'b0;
                            out_s      = 1'b1;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 3'd1;
                            out_s     = shift_r[1];
                        end
                    end else begin
                        out_s = shift_r[0];
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            done_s     = 1'b1;
                            stop_cnt_s = 1'b0;
                            if (start) begin
                                shift_s = in;
                                state_s = START;
                                out_s   = 1'b0;
                                busy_s  = 1'b1;
                                clear_s = 1'b1;
                            end else begin
                                state_s = IDLE;
                                out_s   = 1'b1;
                                busy_s  = 1'b0;
                            end
                        end else begin
                            stop_cnt_s = stop_cnt_r + 1'b1;
                        end
                    end else begin
                        out_s = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    out_s   = 1'b1;
                    busy_s  = 1'b0;
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // State, datapath and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            out_r      <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            out_r      <= out_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Directed bench for uart8_transmitter: reset, single frames, back-to-back,
// abort and a two-stop-bit instance, with bit-centre sampling of the line.
module tb_uart8_transmitter;

    localparam int CPB = 1250;

    logic       clk = 1'b0;
    logic       rst;
    logic       en1, start1, out1, busy1, done1;
    logic       en2, start2, out2, busy2, done2;
    logic [7:0] in1, in2;

    int total = 0;
    int bad   = 0;

    // 100 MHz nominal bench clock; only cycle counts matter.
    always #5 clk = ~clk;

    uart8_transmitter #(.STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .start(start1), .in(in1),
        .out(out1), .busy(busy1), .done(done1)
    );

    uart8_transmitter #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .start(start2), .in(in2),
        .out(out2), .busy(busy2), .done(done2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic get(input int which, output logic o, output logic b, output logic d);
        if (which == 0) begin
            o = out1; b = busy1; d = done1;
        end else begin
            o = out2; b = busy2; d = done2;
        end
    endtask

    task automatic set_start(input int which, input logic v, input logic [7:0] data);
        if (which == 0) begin
            start1 = v; in1 = data;
        end else begin
            start2 = v; in2 = data;
        end
    endtask

    // Raise start for one edge (or keep it high) and check zero-latency launch.
    task automatic launch(input string tag, input int which, input logic [7:0] data, input bit hold);
        logic o, b, d;
        set_start(which, 1'b1, data);
        step(1);
        if (!hold) set_start(which, 1'b0, data);
        get(which, o, b, d);
        check_val({tag, "_launch_out"}, o, 1'b0);
        check_val({tag, "_launch_busy"}, b, 1'b1);
    endtask

    // Follow the line for nbits bit periods from the launch edge, sampling
    // each bit centre, then check the end-of-frame edge.
    task automatic watch(input string tag, input int which, input logic [31:0] bits,
                         input int nbits, input int pulse_at, input int drop_at,
                         output int done_cnt, output int done_pos);
        int   busy_cnt;
        logic o, b, d;
        busy_cnt = 0;
        done_cnt = 0;
        done_pos = -1;
        for (int c = 0; c < nbits * CPB; c++) begin
            get(which, o, b, d);
            if (b) busy_cnt++;
            if (d) begin
                done_cnt++;
                if (done_pos < 0) done_pos = c;
            end
            if (c % CPB == CPB / 2)
                check_val($sformatf("%s_bit%0d", tag, c / CPB), o, bits[c / CPB]);
            if (pulse_at >= 0 && c == pulse_at) set_start(which, 1'b1, 8'hFF);
            if (pulse_at >= 0 && c == pulse_at + 1) set_start(which, 1'b0, 8'hFF);
            if (c == drop_at) set_start(which, 1'b0, 8'h00);
            step(1);
        end
        check_val({tag, "_busy_len"}, busy_cnt, nbits * CPB);
        get(which, o, b, d);
        check_val({tag, "_end_done"}, d, 1'b1);
        check_val({tag, "_end_busy"}, b, 1'b0);
        check_val({tag, "_end_out"}, o, 1'b1);
    endtask

    initial begin
        int   dc, dp, cnt;
        logic o, b, d;

        rst = 1'b1; en1 = 1'b1; en2 = 1'b1;
        start1 = 1'b1; start2 = 1'b1; in1 = 8'hAA; in2 = 8'h00;

        // Reset held with start and en high.
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_val($sformatf("rst_out_%0d", i), out1, 1'b1);
            check_val($sformatf("rst_busy_%0d", i), busy1, 1'b0);
            check_val($sformatf("rst_done_%0d", i), done1, 1'b0);
        end
        check_val("rst_busy2", busy2, 1'b0);
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
        step(3);
        check_val("post_rst_busy", busy1, 1'b0);

        // en low blocks a start request in IDLE.
        en1 = 1'b0; start1 = 1'b1;
        step(3);
        check_val("en0_busy", busy1, 1'b0);
        check_val("en0_out", out1, 1'b1);
        start1 = 1'b0; en1 = 1'b1;
        step(1);

        // Reset mid-frame returns to idle at once.
        launch("rstmid", 0, 8'h00, 1'b0);
        step(100);
        check_val("rstmid_pre_out", out1, 1'b0);
        rst = 1'b1;
        step(1);
        check_val("rstmid_out", out1, 1'b1);
        check_val("rstmid_busy", busy1, 1'b0);
        check_val("rstmid_done", done1, 1'b0);
        rst = 1'b0;
        step(2);
        check_val("rstmid_idle", busy1, 1'b0);

        // Single frame 0x56.
        launch("single", 0, 8'h56, 1'b0);
        watch("single", 0, {22'd0, 1'b1, 8'h56, 1'b0}, 10, -1, -1, dc, dp);
        check_val("single_done_inside", dc, 0);
        step(1);
        check_val("single_done_width", done1, 1'b0);
        check_val("single_idle_busy", busy1, 1'b0);
        step(5);

        // Back-to-back 0x00 then 0xFF with start held; in changes mid-frame.
        launch("b2b", 0, 8'h00, 1'b1);
        in1 = 8'hFF;
        watch("b2b", 0, {12'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20,
              -1, 10 * CPB + 5, dc, dp);
        check_val("b2b_done_cnt", dc, 1);
        check_val("b2b_done_pos", dp, 10 * CPB);
        step(1);
        check_val("b2b_done_width", done1, 1'b0);
        step(5);

        // Abort 3000 cycles into a frame of 0x3C, then a clean frame.
        launch("abort", 0, 8'h3C, 1'b0);
        step(2999);
        check_val("abort_pre_out", out1, 1'b0);
        en1 = 1'b0;
        step(1);
        check_val("abort_out", out1, 1'b1);
        check_val("abort_busy", busy1, 1'b0);
        check_val("abort_done", done1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            get(0, o, b, d);
            if (d || b || !o) cnt++;
            step(1);
        end
        check_val("abort_quiet", cnt, 0);
        en1 = 1'b1;
        step(1);
        launch("reframe", 0, 8'h3C, 1'b0);
        watch("reframe", 0, {22'd0, 1'b1, 8'h3C, 1'b0}, 10, -1, -1, dc, dp);
        check_val("reframe_done_inside", dc, 0);

        // Two stop bits, 0x55, with a stray start pulse mid-frame.
        launch("stop2", 1, 8'h55, 1'b0);
        watch("stop2", 1, {21'd0, 2'b11, 8'h55, 1'b0}, 11, 5000, -1, dc, dp);
        check_val("stop2_done_inside", dc, 0);
        step(1);
        check_val("stop2_idle_busy", busy2, 1'b0);
        check_val("stop2_done_width", done2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
